// File: rtl/efuse_pkg.sv
// efuse_pkg: shared types and constants for the eFuse macro sequencer.
//   - efuse_seq_state_e : sequencer FSM state encoding (VF_* used only by the
//                         optional program-verify readback)
//   - EFUSE_T_*         : default macro timing, in clk cycles
//   - EFUSE_BITS/BYTES  : macro organisation (256 bits, 32 bytes of 8-bit DOUT)
package efuse_pkg;

  localparam int EFUSE_BITS  = 256;
  localparam int EFUSE_BYTES = 32;

  localparam int EFUSE_T_SU  = 2;
  localparam int EFUSE_T_RD  = 4;
  localparam int EFUSE_T_HD  = 2;
  localparam int EFUSE_T_PGM = 200;

  typedef enum logic [3:0] {
    IDLE,
    RD_SU,
    RD_STB,
    RD_HD,
    WR_SCAN,
    WR_SU,
    WR_PGM,
    WR_HD,
    DONE,
    VF_SU,
    VF_STB,
    VF_HD
  } efuse_seq_state_e;

endpackage

// File: rtl/efuse_phase_timer.sv
// efuse_phase_timer: down-counter shared by every timed macro phase.
// A load pulse arms the counter with a phase length; expire is high during the
// last cycle of that phase (immediately for a length of 1).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : start a new phase on the next edge
//   len        : phase length in cycles (>= 1)
//   expire     : last cycle of the current phase
module efuse_phase_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= len - 1'b1;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/efuse_macro_seq.sv
// efuse_macro_seq: responder for the eFuse read/write start/done handshake that
// drives the 256-bit eFuse hard macro pins with setup / strobe / hold timing.
// Reads walk NR/8 bytes; programming scans NW bits and pulses only the 1s.
// Optional build macro EFUSE_WR_VERIFY_EN: after a program scan, read the word
// back and flag write_err if any bit written as 1 reads back 0.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   read_start, read_sel           : read request and NR-bit word index
//   read_done, read_data           : completion pulse and read word (held)
//   efuse_busy_read                : read in progress
//   write_start, write_sel, write_data : program request, word index, bits to blow
//   write_done, efuse_busy_write   : completion pulse, program in progress
//   write_err                      : verify failure (0 without EFUSE_WR_VERIFY_EN)
//   efuse_csb/load/pgenb/strobe/addr : macro control pins (all registered)
//   efuse_dout                     : macro read byte
//
// state   | meaning
// IDLE    | waiting for read_start / write_start
// RD_SU   | read byte: address/mode setup
// RD_STB  | read byte: strobe high, DOUT captured on last cycle
// RD_HD   | read byte: hold after strobe
// WR_SCAN | one cycle per write bit, skip zeros
// WR_SU   | program bit: address/pgenb setup
// WR_PGM  | program bit: strobe high
// WR_HD   | program bit: hold after strobe
// VF_*    | verify readback, same timing as RD_*
// DONE    | one-cycle done pulse
module efuse_macro_seq
  import efuse_pkg::*;
#(
  parameter int NW    = 64,
  parameter int NR    = 64,
  parameter int T_SU  = EFUSE_T_SU,
  parameter int T_RD  = EFUSE_T_RD,
  parameter int T_HD  = EFUSE_T_HD,
  parameter int T_PGM = EFUSE_T_PGM,
  parameter int CNT_W = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                read_start,
  input  logic [$clog2(EFUSE_BITS/NR)-1:0]    read_sel,
  output logic                                read_done,
  output logic [NR-1:0]                       read_data,
  output logic                                efuse_busy_read,
  input  logic                                write_start,
  input  logic [$clog2(EFUSE_BITS/NW)-1:0]    write_sel,
  input  logic [NW-1:0]                       write_data,
  output logic                                write_done,
  output logic                                efuse_busy_write,
  output logic                                write_err,
  output logic                                efuse_csb,
  output logic                                efuse_load,
  output logic                                efuse_pgenb,
  output logic                                efuse_strobe,
  output logic [7:0]                          efuse_addr,
  input  logic [7:0]                          efuse_dout
);

  localparam int              BI_W     = (NW > 1) ? $clog2(NW) : 1;
  localparam int              BUF_W    = (NR > NW) ? NR : NW;
  localparam logic [4:0]      RD_LAST  = 5'(NR/8 - 1);
  localparam logic [BI_W-1:0] BIT_LAST = BI_W'(NW - 1);
`ifdef EFUSE_WR_VERIFY_EN
  localparam logic [4:0]      VF_LAST  = 5'(NW/8 - 1);
`endif

  efuse_seq_state_e state, state_next, scan_end;

  logic [4:0]                         byte_idx, byte_nxt;
  logic [4:0]                         base_byte, base_nxt;
  logic [BI_W-1:0]                    bit_idx, bit_nxt;
  logic                               is_wr, is_wr_nxt;
  logic                               wr_accept;
  logic [$clog2(EFUSE_BITS/NW)-1:0]   wsel_q;
  logic [NW-1:0]                      wdata_q;
  logic [BUF_W-1:0]                   rbuf;

  logic             tmr_load, tmr_expire;
  logic [CNT_W-1:0] tmr_len;

  logic       csb_d, load_d, pgenb_d, strobe_d;
  logic       rd_done_d, wr_done_d, busy_rd_d, busy_wr_d;
  logic [7:0] addr_d;

  // End of the program scan either finishes or hands over to the readback.
`ifdef EFUSE_WR_VERIFY_EN
  assign scan_end = VF_SU;
`else
  assign scan_end = DONE;
`endif

  // read wins a simultaneous request; write is simply dropped
  assign wr_accept = (state == IDLE) && !read_start && write_start;

  efuse_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .len    (tmr_len),
    .expire (tmr_expire)
  );

  // state register and per-operation context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      byte_idx  <= '0;
      base_byte <= '0;
      bit_idx   <= '0;
      is_wr     <= 1'b0;
      wsel_q    <= '0;
      wdata_q   <= '0;
      rbuf      <= '0;
    end else begin
      state     <= state_next;
      byte_idx  <= byte_nxt;
      base_byte <= base_nxt;
      bit_idx   <= bit_nxt;
      is_wr     <= is_wr_nxt;
      if (wr_accept) begin
        wsel_q  <= write_sel;
        wdata_q <= write_data;
      end
      if ((state == RD_STB || state == VF_STB) && tmr_expire) begin
        rbuf[byte_idx*8 +: 8] <= efuse_dout;
      end
    end
  end

  // next-state logic
  always_comb begin
    state_next = state;
    byte_nxt   = byte_idx;
    base_nxt   = base_byte;
    bit_nxt    = bit_idx;
    is_wr_nxt  = is_wr;
    case (state)
      IDLE: begin
        if (read_start) begin
          state_next = RD_SU;
          byte_nxt   = '0;
          base_nxt   = 5'(read_sel * (NR/8));
          is_wr_nxt  = 1'b0;
        end else if (write_start) begin
          state_next = WR_SCAN;
          byte_nxt   = '0;
          base_nxt   = 5'(write_sel * (NW/8));
          bit_nxt    = '0;
          is_wr_nxt  = 1'b1;
        end
      end
      RD_SU:  if (tmr_expire) state_next = RD_STB;
      RD_STB: if (tmr_expire) state_next = RD_HD;
      RD_HD: begin
        if (tmr_expire) begin
          if (byte_idx == RD_LAST) begin
            state_next = DONE;
          end else begin
            state_next = RD_SU;
            byte_nxt   = byte_idx + 5'd1;
          end
        end
      end
      WR_SCAN: begin
        if (wdata_q[bit_idx]) begin
          state_next = WR_SU;
        end else if (bit_idx == BIT_LAST) begin
          state_next = scan_end;
          byte_nxt   = '0;
        end else begin
          bit_nxt = bit_idx + 1'b1;
        end
      end
      WR_SU:  if (tmr_expire) state_next = WR_PGM;
      WR_PGM: if (tmr_expire) state_next = WR_HD;
      WR_HD: begin
        if (tmr_expire) begin
          if (bit_idx == BIT_LAST) begin
            state_next = scan_end;
            byte_nxt   = '0;
          end else begin
            state_next = WR_SCAN;
            bit_nxt    = bit_idx + 1'b1;
          end
        end
      end
`ifdef EFUSE_WR_VERIFY_EN
      VF_SU:  if (tmr_expire) state_next = VF_STB;
      VF_STB: if (tmr_expire) state_next = VF_HD;
      VF_HD: begin
        if (tmr_expire) begin
          if (byte_idx == VF_LAST) begin
            state_next = DONE;
          end else begin
            state_next = VF_SU;
            byte_nxt   = byte_idx + 5'd1;
          end
        end
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered pins line up
  // with the state they belong to; the timer is armed on every phase entry.
  always_comb begin
    csb_d     = 1'b1;
    load_d    = 1'b0;
    pgenb_d   = 1'b1;
    strobe_d  = 1'b0;
    addr_d    = '0;
    tmr_load  = 1'b0;
    tmr_len   = CNT_W'(T_SU);
    case (state_next)
      RD_SU, RD_HD, VF_SU, VF_HD: begin
        csb_d  = 1'b0;
        load_d = 1'b1;
        addr_d = {5'(base_nxt + byte_nxt), 3'b000};
      end
      RD_STB, VF_STB: begin
        csb_d    = 1'b0;
        load_d   = 1'b1;
        strobe_d = 1'b1;
        addr_d   = {5'(base_nxt + byte_nxt), 3'b000};
      end
      WR_SU, WR_HD: begin
        csb_d   = 1'b0;
        pgenb_d = 1'b0;
        addr_d  = 8'(wsel_q * NW + bit_nxt);
      end
      WR_PGM: begin
        csb_d    = 1'b0;
        pgenb_d  = 1'b0;
        strobe_d = 1'b1;
        addr_d   = 8'(wsel_q * NW + bit_nxt);
      end
      default: ;
    endcase
    case (state_next)
      RD_SU, WR_SU, VF_SU:   tmr_len = CNT_W'(T_SU);
      RD_STB, VF_STB:        tmr_len = CNT_W'(T_RD);
      WR_PGM:                tmr_len = CNT_W'(T_PGM);
      RD_HD, WR_HD, VF_HD:   tmr_len = CNT_W'(T_HD);
      default:               tmr_len = CNT_W'(T_SU);
    endcase
    case (state_next)
      RD_SU, RD_STB, RD_HD, WR_SU, WR_PGM, WR_HD, VF_SU, VF_STB, VF_HD:
        tmr_load = (state_next != state);
      default: tmr_load = 1'b0;
    endcase
  end

  assign busy_rd_d = (state_next != IDLE) && !is_wr_nxt;
  assign busy_wr_d = (state_next != IDLE) && is_wr_nxt;
  assign rd_done_d = (state_next == DONE) && !is_wr_nxt;
  assign wr_done_d = (state_next == DONE) && is_wr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      efuse_csb        <= 1'b1;
      efuse_load       <= 1'b0;
      efuse_pgenb      <= 1'b1;
      efuse_strobe     <= 1'b0;
      efuse_addr       <= '0;
      read_done        <= 1'b0;
      write_done       <= 1'b0;
      efuse_busy_read  <= 1'b0;
      efuse_busy_write <= 1'b0;
      read_data        <= '0;
    end else begin
      efuse_csb        <= csb_d;
      efuse_load       <= load_d;
      efuse_pgenb      <= pgenb_d;
      efuse_strobe     <= strobe_d;
      efuse_addr       <= addr_d;
      read_done        <= rd_done_d;
      write_done       <= wr_done_d;
      efuse_busy_read  <= busy_rd_d;
      efuse_busy_write <= busy_wr_d;
      if (rd_done_d) begin
        read_data <= rbuf[NR-1:0];
      end
    end
  end

`ifdef EFUSE_WR_VERIFY_EN
  logic err_q;

  // a bit that was blown but reads back 0 is a failed program
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (wr_accept) begin
      err_q <= 1'b0;
    end else if (wr_done_d) begin
      err_q <= |(wdata_q & ~rbuf[NW-1:0]);
    end
  end

  assign write_err = err_q;
`else
  assign write_err = 1'b0;
`endif

endmodule

// File: tb/tb_efuse_macro_seq.sv
module tb_efuse_macro_seq;

`ifdef EFUSE_WR_VERIFY_EN
  localparam int VF_LAT = 64;
  localparam bit VF_ON  = 1'b1;
`else
  localparam int VF_LAT = 0;
  localparam bit VF_ON  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        read_start = 1'b0;
  logic [1:0]  read_sel = '0;
  logic        read_done;
  logic [63:0] read_data;
  logic        efuse_busy_read;
  logic        write_start = 1'b0;
  logic [1:0]  write_sel = '0;
  logic [63:0] write_data = '0;
  logic        write_done;
  logic        efuse_busy_write;
  logic        write_err;
  logic        efuse_csb, efuse_load, efuse_pgenb, efuse_strobe;
  logic [7:0]  efuse_addr;
  logic [7:0]  efuse_dout;

  int n_checks = 0;
  int n_fail   = 0;

  // macro model
  logic [255:0] fuse;
  logic [255:0] stuck;

  // scoreboard queues
  logic [7:0]  addr_q[$];
  logic [63:0] rd_q[$];

  logic       strobe_prev = 1'b0;
  int         stb_len = 0;
  logic       stb_pgm = 1'b0;
  logic [7:0] stb_addr = '0;
  int         rd_done_cnt = 0;
  int         wr_done_cnt = 0;

  always #5 clk = ~clk;

  assign efuse_dout = (!efuse_csb && efuse_load) ? fuse[{efuse_addr[7:3], 3'b000} +: 8] : 8'h00;

  efuse_macro_seq dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .read_start       (read_start),
    .read_sel         (read_sel),
    .read_done        (read_done),
    .read_data        (read_data),
    .efuse_busy_read  (efuse_busy_read),
    .write_start      (write_start),
    .write_sel        (write_sel),
    .write_data       (write_data),
    .write_done       (write_done),
    .efuse_busy_write (efuse_busy_write),
    .write_err        (write_err),
    .efuse_csb        (efuse_csb),
    .efuse_load       (efuse_load),
    .efuse_pgenb      (efuse_pgenb),
    .efuse_strobe     (efuse_strobe),
    .efuse_addr       (efuse_addr),
    .efuse_dout       (efuse_dout)
  );

  // pin monitor: strobe addresses/widths, read data, programming of the model
  always @(negedge clk) begin
    logic [7:0]  ea;
    logic [63:0] ed;
    int          el;
    if (efuse_strobe && !strobe_prev) begin
      stb_len  = 1;
      stb_pgm  = !efuse_pgenb;
      stb_addr = efuse_addr;
      n_checks++;
      if (addr_q.size() == 0) begin
        n_fail++;
        $display("FAIL strobe_unexpected: got addr %0d, none expected", efuse_addr);
      end else begin
        ea = addr_q.pop_front();
        if (efuse_addr !== ea) begin
          n_fail++;
          $display("FAIL strobe_addr: got %0d expected %0d", efuse_addr, ea);
        end
      end
      n_checks++;
      if (efuse_csb !== 1'b0 || efuse_pgenb !== efuse_load) begin
        n_fail++;
        $display("FAIL strobe_mode: got csb=%0b load=%0b pgenb=%0b", efuse_csb, efuse_load, efuse_pgenb);
      end
    end else if (efuse_strobe) begin
      stb_len++;
    end
    if (!efuse_strobe && strobe_prev && rst_n) begin
      el = stb_pgm ? 200 : 4;
      n_checks++;
      if (stb_len !== el) begin
        n_fail++;
        $display("FAIL strobe_width: got %0d expected %0d", stb_len, el);
      end
      if (stb_pgm && !stuck[stb_addr]) fuse[stb_addr] = 1'b1;
    end
    if (read_done) begin
      rd_done_cnt++;
      n_checks++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL read_done_unexpected: got data %h", read_data);
      end else begin
        ed = rd_q.pop_front();
        if (read_data !== ed) begin
          n_fail++;
          $display("FAIL read_data: got %h expected %h", read_data, ed);
        end
      end
    end
    if (write_done) wr_done_cnt++;
    if (efuse_busy_read && efuse_busy_write) begin
      n_checks++;
      n_fail++;
      $display("FAIL busy_both: got busy_read=1 busy_write=1 expected not both");
    end
    strobe_prev = efuse_strobe;
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if ({efuse_csb, efuse_pgenb, efuse_load, efuse_strobe, efuse_addr} !== {4'b1100, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_pins: got csb=%0b pgenb=%0b load=%0b strobe=%0b addr=%0h",
               efuse_csb, efuse_pgenb, efuse_load, efuse_strobe, efuse_addr);
    end
    n_checks++;
    if ({read_done, write_done, efuse_busy_read, efuse_busy_write, write_err} !== 5'b0 ||
        read_data !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_status: got flags=%05b data=%h expected 0",
               {read_done, write_done, efuse_busy_read, efuse_busy_write, write_err}, read_data);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_read(input logic [1:0] sel, input logic [63:0] exp_data, input string name);
    int cnt;
    for (int b = 0; b < 8; b++) addr_q.push_back({5'(sel * 8 + b), 3'b000});
    rd_q.push_back(exp_data);
    @(negedge clk);
    read_start = 1'b1;
    read_sel   = sel;
    @(negedge clk);
    read_start = 1'b0;
    cnt = 1;
    n_checks++;
    if (efuse_busy_read !== 1'b1 || efuse_busy_write !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_busy: got busy_read=%0b busy_write=%0b expected 1/0", name, efuse_busy_read, efuse_busy_write);
    end
    while (read_done !== 1'b1 && cnt < 500) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (cnt !== 65) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d expected 65", name, cnt);
    end
    @(negedge clk);
    n_checks++;
    if (efuse_busy_read !== 1'b0 || read_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_end: got busy=%0b done=%0b expected 0/0", name, efuse_busy_read, read_done);
    end
    n_checks++;
    if (addr_q.size() != 0 || rd_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending: got %0d strobes %0d reads outstanding expected 0", name, addr_q.size(), rd_q.size());
    end
  endtask

  task automatic run_write(input logic [1:0] sel, input logic [63:0] data, input bit exp_err,
                           input int exp_lat, input string name);
    int cnt;
    int rd0;
    rd0 = rd_done_cnt;
    for (int i = 0; i < 64; i++) if (data[i]) addr_q.push_back(8'(sel * 64 + i));
    if (VF_ON) for (int b = 0; b < 8; b++) addr_q.push_back({5'(sel * 8 + b), 3'b000});
    @(negedge clk);
    write_start = 1'b1;
    write_sel   = sel;
    write_data  = data;
    @(negedge clk);
    write_start = 1'b0;
    cnt = 1;
    n_checks++;
    if (efuse_busy_write !== 1'b1 || efuse_busy_read !== 1'b0 || write_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_accept: got busy_write=%0b busy_read=%0b err=%0b expected 1/0/0",
               name, efuse_busy_write, efuse_busy_read, write_err);
    end
    while (write_done !== 1'b1 && cnt < 20000) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (cnt !== exp_lat) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d expected %0d", name, cnt, exp_lat);
    end
    n_checks++;
    if (write_err !== exp_err) begin
      n_fail++;
      $display("FAIL %s_err: got %0b expected %0b", name, write_err, exp_err);
    end
    @(negedge clk);
    n_checks++;
    if (efuse_busy_write !== 1'b0 || write_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_end: got busy=%0b done=%0b expected 0/0", name, efuse_busy_write, write_done);
    end
    n_checks++;
    if (addr_q.size() != 0 || rd_done_cnt != rd0) begin
      n_fail++;
      $display("FAIL %s_pending: got %0d strobes outstanding, %0d read_done expected 0/0",
               name, addr_q.size(), rd_done_cnt - rd0);
    end
  endtask

  task automatic test_arbitration();
    int cnt;
    int first;
    int bw;
    int rd0;
    int wr0;
    for (int b = 0; b < 8; b++) addr_q.push_back({5'(b), 3'b000});
    rd_q.push_back(fuse[63:0]);
    rd0 = rd_done_cnt;
    wr0 = wr_done_cnt;
    first = 0;
    bw = 0;
    @(negedge clk);
    read_start  = 1'b1;
    write_start = 1'b1;
    read_sel    = 2'd0;
    write_sel   = 2'd0;
    write_data  = '1;
    @(negedge clk);
    write_start = 1'b0;
    cnt = 1;
    while (cnt < 140) begin
      if (efuse_busy_write) bw++;
      if (read_done && first == 0) first = cnt;
      if (cnt == 3) read_start = 1'b0;
      if (cnt == 10) begin
        read_start  = 1'b1;
        write_start = 1'b1;
      end
      if (cnt == 11) begin
        read_start  = 1'b0;
        write_start = 1'b0;
      end
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (first !== 65) begin
      n_fail++;
      $display("FAIL arb_latency: got %0d expected 65", first);
    end
    n_checks++;
    if (bw !== 0) begin
      n_fail++;
      $display("FAIL arb_busy_write: got %0d busy cycles expected 0", bw);
    end
    n_checks++;
    if (rd_done_cnt - rd0 !== 1 || wr_done_cnt - wr0 !== 0) begin
      n_fail++;
      $display("FAIL arb_ops: got %0d reads %0d writes expected 1/0", rd_done_cnt - rd0, wr_done_cnt - wr0);
    end
    n_checks++;
    if (addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL arb_pending: got %0d strobes outstanding expected 0", addr_q.size());
    end
  endtask

  task automatic test_reset_mid_pgm();
    int cnt;
    int wr0;
    wr0 = wr_done_cnt;
    addr_q.push_back(8'd192);
    @(negedge clk);
    write_start = 1'b1;
    write_sel   = 2'd3;
    write_data  = 64'h1;
    @(negedge clk);
    write_start = 1'b0;
    cnt = 1;
    while (!(efuse_strobe && !efuse_pgenb) && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (cnt !== 4) begin
      n_fail++;
      $display("FAIL rst_pgm_start: got strobe at %0d expected 4", cnt);
    end
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({efuse_strobe, efuse_pgenb, efuse_csb, efuse_busy_write} !== 4'b0110) begin
      n_fail++;
      $display("FAIL rst_pgm_pins: got strobe=%0b pgenb=%0b csb=%0b busy=%0b expected 0/1/1/0",
               efuse_strobe, efuse_pgenb, efuse_csb, efuse_busy_write);
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (wr_done_cnt !== wr0 || efuse_busy_write !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_pgm_done: got %0d write_done busy=%0b expected 0/0", wr_done_cnt - wr0, efuse_busy_write);
    end
    n_checks++;
    if (addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL rst_pgm_pending: got %0d strobes outstanding expected 0", addr_q.size());
    end
    run_read(2'd1, fuse[127:64], "rd_after_rst");
  endtask

  task automatic test_verify();
    run_write(2'd1, 64'h0000_0000_0000_0120, VF_ON, 65 + 2 * 204 + VF_LAT, "vf_stuck");
    run_write(2'd1, 64'h0000_0000_0000_0100, 1'b0, 65 + 204 + VF_LAT, "vf_clean");
  endtask

  initial begin
    fuse  = '0;
    stuck = '0;
    for (int b = 0; b < 8; b++) fuse[b*8 +: 8] = 8'(8'hA0 + b);
    for (int b = 8; b < 16; b++) fuse[b*8 +: 8] = 8'(b - 7);
    stuck[69] = 1'b1;

    test_reset();
    run_read(2'd1, 64'h0807_0605_0403_0201, "rd_plan");
    run_write(2'd2, 64'h8000_0000_0000_0001, 1'b0, 473 + VF_LAT, "wr_two_bits");
    run_read(2'd2, 64'h8000_0000_0000_0001, "rd_back");
    run_write(2'd3, 64'h0, 1'b0, 65 + VF_LAT, "wr_zero");
    test_arbitration();
    test_reset_mid_pgm();
    test_verify();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
